// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: PC mux encodings, NOP word, fetch state codes.
package instr_fetch_pkg;

    localparam logic [1:0]  PC_NEXT   = 2'b00;
    localparam logic [1:0]  PC_BRANCH = 2'b01;
    localparam logic [1:0]  PC_JUMP   = 2'b10;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // FETCH: request live, result wanted; DRAIN: request live, result stale;
    // HOLD: result parked while decode is stalled, no request on the bus.
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_DRAIN = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or squash it to a NOP bubble.
module if_id_reg
    import instr_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    // Flush wins over load; pc_plus4 is left alone on a flush.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q    <= NOP;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem request,
// redirect draining, stall buffering and the IF/ID register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [1:0]  pc_mux_ctrl_i,
    input  logic [31:0] branch_addr_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  hold_data_q, hold_data_d;

    logic         redirect;
    logic         flush_eff;
    logic [31:0]  target;
    logic [31:0]  seq_addr;
    logic         ifid_load;
    logic [31:0]  ifid_instr;

    // Control inputs only count while decode is not stalled.
    assign redirect  = !stall_i && ((pc_mux_ctrl_i == PC_BRANCH) || (pc_mux_ctrl_i == PC_JUMP));
    assign flush_eff = flush_i && !stall_i;
    assign target    = word_align((pc_mux_ctrl_i == PC_JUMP) ? jump_addr_i : branch_addr_i);
    assign seq_addr  = req_addr_q + PC_STEP;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        hold_data_d = hold_data_q;
        ifid_load   = 1'b0;
        ifid_instr  = imem_data_i;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    pc_d = target;
                    // A response landing this cycle is dropped; otherwise wait it out.
                    if (imem_ready_i) begin
                        req_addr_d = target;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ready_i) begin
                    if (stall_i) begin
                        hold_data_d = imem_data_i;
                        state_d     = ST_HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        pc_d       = seq_addr;
                        req_addr_d = seq_addr;
                    end
                end
            end

            ST_DRAIN: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ready_i) begin
                    req_addr_d = redirect ? target : pc_q;
                    state_d    = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_d        = target;
                    req_addr_d  = target;
                    hold_data_d = '0;
                    state_d     = ST_FETCH;
                end else if (!stall_i) begin
                    ifid_load   = 1'b1;
                    ifid_instr  = hold_data_q;
                    pc_d        = seq_addr;
                    req_addr_d  = seq_addr;
                    hold_data_d = '0;
                    state_d     = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign imem_req_o  = (state_q != ST_HOLD);
    assign imem_addr_o = req_addr_q;

    if_id_reg u_if_id_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ifid_load),
        .flush_i    (flush_eff),
        .instr_i    (ifid_instr),
        .pc_plus4_i (seq_addr),
        .instr_o    (instr_o),
        .pc_plus4_o (pc_plus4_o),
        .valid_o    (valid_o)
    );

endmodule
